fp_result_wb: RTL and testbench
===============================

// Module: fp_result_wb
// PURPOSE
//   FP unit writeback stage, directly downstream of the single/double conversion stage and the other FP datapaths.
//   Registers each FP result behind a valid/ready handshake, NaN-boxes single-precision results into 64 bits and holds
//   a 2-entry skid buffer. Accumulates per-result exception flags into the sticky fflags CSR at the commit point.
// PARAMETERS
//   DATA_WIDTH  64  result width; only 64 is supported
//   FLAG_WIDTH  5   exception flags {NV,DZ,OF,UF,NX}, bit4..bit0
//   RD_WIDTH    5   destination register index width
// PORTS
//   in_clk        in   1    clock; all state updates on the rising edge
//   in_rst_n      in   1    synchronous reset, active-low
//   in_valid      in   1    upstream result valid
//   out_ready     out  1    stage can accept (registered; = skid entry empty)
//   in_data       in   64   result; single results occupy [31:0]
//   in_fmt        in   1    1 = single-precision result, 0 = double
//   in_flags      in   5    exception flags raised by this result (NX from conversion stage etc.)
//   in_rd         in   5    destination FP register
//   out_valid     out  1    head entry valid toward register file
//   in_ready      in   1    register file accepts head this cycle
//   out_data      out  64   head result, NaN-boxed when single
//   out_rd        out  5    head destination register
//   out_flags     out  5    head result flags
//   in_flush      in   1    discard all buffered results
//   in_csr_we     in   1    CSR write to fflags
//   in_csr_wdata  in   5    CSR write data
//   out_fflags    out  5    sticky accumulated flags
// BEHAVIOUR
//   - Reset (in_rst_n=0 at edge): both entries invalid, out_valid=0, out_data=0, out_rd=0, out_flags=0, out_fflags=0;
//     out_ready=1 from the first cycle after reset. Reset mid-operation discards buffered results without committing them.
//   - Accept = in_valid & out_ready. Commit = out_valid & in_ready. Results are committed in strict FIFO order.
//   - Latency: a result accepted at edge N presents out_valid=1 in cycle N+1 when the head is empty or committing.
//     Sustained throughput is 1 result per cycle with in_ready held high.
//   - Skid: on accept while head valid and no commit, the result goes to the skid entry; out_ready=0 from the next cycle.
//     On commit with skid valid, skid moves to head and out_ready=1 next cycle; a same-cycle accept is impossible then.
//   - Accept and commit in the same cycle with skid empty: the new result replaces the head; no bubble.
//   - Capture transform (applied when written into an entry):
//       in_fmt=1 -> data = {32'hFFFF_FFFF, in_data[31:0]}; in_fmt=0 -> data = in_data.
//   - fflags: next = (in_csr_we ? in_csr_wdata : out_fflags) | (commit ? out_flags : 5'b0).
//     A CSR write and a commit in the same cycle both take effect; the OR is applied after the write.
//   - Flush (in_flush=1): both entries invalidated at the edge; out_valid=0 and out_ready=1 next cycle.
//     Flush has priority over commit and accept in the same cycle: no commit, no fflags contribution from flushed entries,
//     and the offered input is dropped. The CSR write is still honoured.
//   - Upstream must hold in_* stable while in_valid & !out_ready. The register file must not sample out_* when out_valid=0.
//     out_data, out_rd and out_flags hold their last value when out_valid=0.
// CONFIGURATION
//   FP_CANON_NAN_EN defined: at capture, a NaN result is replaced by the canonical NaN.
//     Single NaN is exp[30:23]=8'hFF with mant[22:0]!=0; it becomes {32'hFFFF_FFFF, 32'h7FC0_0000}.
//     Double NaN is exp[62:52]=11'h7FF with mant!=0; it becomes 64'h7FF8_0000_0000_0000.
//     in_flags pass through unchanged.
//   FP_CANON_NAN_EN undefined: NaN payloads pass through unmodified; only NaN-boxing is applied.
// TESTING
//   1 Reset: in_rst_n=0 for 2 cycles -> out_valid=0, out_fflags=0, out_ready=1 in the first cycle after release.
//   2 Single result: in_data=64'h0000_0000_3F80_0000, in_fmt=1, in_rd=3, in_ready=1 -> next cycle out_valid=1,
//     out_data=64'hFFFF_FFFF_3F80_0000, out_rd=3.
//   3 Backpressure: in_ready=0, accept 2 results (rd=1,2) -> out_ready=0 after the 2nd, a 3rd offer is not accepted;
//     raise in_ready -> commits rd=1 then rd=2 on consecutive cycles, out_ready=1 again.
//   4 Flags: commit results with flags 5'b00001 then 5'b00100 -> out_fflags=5'b00101. Then csr_we=1, wdata=0 in the same
//     cycle as a commit with flags 5'b10000 -> out_fflags=5'b10000.
//   5 Flush: both entries full with flags 5'b01000, in_flush=1 with in_ready=1 -> out_valid=0, out_fflags unchanged,
//     out_ready=1 next cycle.
//   6 FP_CANON_NAN_EN: in_data=64'h0000_0000_7F80_0001, in_fmt=1 -> out_data=64'hFFFF_FFFF_7FC0_0000.
//     Without the macro -> out_data=64'hFFFF_FFFF_7F80_0001.

Source files
------------

// File: rtl/fp_result_wb.sv
// fp_result_wb: FP unit writeback stage.
//   Each FP result is registered behind a valid/ready handshake. Single-precision
//   results are NaN-boxed into 64 bits when captured. A 2-entry buffer (head plus
//   skid) lets the stage absorb one result while the register file stalls. The
//   exception flags of each committed result are ORed into the sticky fflags CSR.
// Optional feature macro: FP_CANON_NAN_EN
//   When defined, any NaN result is replaced by the canonical NaN at capture.
//   When undefined, NaN payloads pass through unchanged; only NaN-boxing is applied.
module fp_result_wb #(
    parameter int DATA_WIDTH = 64,
    parameter int FLAG_WIDTH = 5,
    parameter int RD_WIDTH   = 5
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_fmt,
    input  logic [FLAG_WIDTH-1:0] in_flags,
    input  logic [RD_WIDTH-1:0]   in_rd,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RD_WIDTH-1:0]   out_rd,
    output logic [FLAG_WIDTH-1:0] out_flags,
    input  logic                  in_flush,
    input  logic                  in_csr_we,
    input  logic [FLAG_WIDTH-1:0] in_csr_wdata,
    output logic [FLAG_WIDTH-1:0] out_fflags
);

    // Capture transform: NaN-box singles, optionally canonicalise NaNs.
    function automatic logic [63:0] capture_data(input logic [63:0] data, input logic fmt);
        logic [63:0] res;
`ifdef FP_CANON_NAN_EN
        if (fmt) begin
            if ((data[30:23] == 8'hFF) && (data[22:0] != 23'd0)) begin
                res = {32'hFFFF_FFFF, 32'h7FC0_0000};
            end else begin
                res = {32'hFFFF_FFFF, data[31:0]};
            end
        end else begin
            if ((data[62:52] == 11'h7FF) && (data[51:0] != 52'd0)) begin
                res = 64'h7FF8_0000_0000_0000;
            end else begin
                res = data;
            end
        end
`else
        if (fmt) begin
            res = {32'hFFFF_FFFF, data[31:0]};
        end else begin
            res = data;
        end
`endif
        return res;
    endfunction

    // Head entry (drives the outputs directly), skid entry, ready and sticky flags.
    logic                  head_valid_r;
    logic [DATA_WIDTH-1:0] head_data_r;
    logic [RD_WIDTH-1:0]   head_rd_r;
    logic [FLAG_WIDTH-1:0] head_flags_r;
    logic                  skid_valid_r;
    logic [DATA_WIDTH-1:0] skid_data_r;
    logic [RD_WIDTH-1:0]   skid_rd_r;
    logic [FLAG_WIDTH-1:0] skid_flags_r;
    logic                  ready_r;
    logic [FLAG_WIDTH-1:0] fflags_r;

    // Next-state values.
    logic                  head_valid_nxt_s;
    logic [DATA_WIDTH-1:0] head_data_nxt_s;
    logic [RD_WIDTH-1:0]   head_rd_nxt_s;
    logic [FLAG_WIDTH-1:0] head_flags_nxt_s;
    logic                  skid_valid_nxt_s;
    logic [DATA_WIDTH-1:0] skid_data_nxt_s;
    logic [RD_WIDTH-1:0]   skid_rd_nxt_s;
    logic [FLAG_WIDTH-1:0] skid_flags_nxt_s;
    logic                  ready_nxt_s;
    logic [FLAG_WIDTH-1:0] fflags_nxt_s;

    logic                  accept_s;
    logic                  commit_s;
    logic [DATA_WIDTH-1:0] cap_data_s;
    logic [FLAG_WIDTH-1:0] fflags_base_s;
    logic [FLAG_WIDTH-1:0] commit_flags_s;

    // Handshake decode and transformed capture data.
    always_comb begin
        accept_s   = in_valid & ready_r;
        commit_s   = head_valid_r & in_ready;
        cap_data_s = capture_data(in_data, in_fmt);
    end

    // fflags: CSR write first, then OR in the committing result's flags.
    always_comb begin
        fflags_base_s  = fflags_r;
        commit_flags_s = {FLAG_WIDTH{1'b0}};
        if (in_csr_we) begin
            fflags_base_s = in_csr_wdata;
        end else begin
            fflags_base_s = fflags_r;
        end
        if (commit_s && !in_flush) begin
            commit_flags_s = head_flags_r;
        end else begin
            commit_flags_s = {FLAG_WIDTH{1'b0}};
        end
        fflags_nxt_s = fflags_base_s | commit_flags_s;
    end

    // Buffer movement: flush beats commit and accept; otherwise FIFO order head->skid.
    always_comb begin
        head_valid_nxt_s = head_valid_r;
        head_data_nxt_s  = head_data_r;
        head_rd_nxt_s    = head_rd_r;
        head_flags_nxt_s = head_flags_r;
        skid_valid_nxt_s = skid_valid_r;
        skid_data_nxt_s  = skid_data_r;
        skid_rd_nxt_s    = skid_rd_r;
        skid_flags_nxt_s = skid_flags_r;
        ready_nxt_s      = ready_r;
        if (in_flush) begin
            head_valid_nxt_s = 1'b0;
            skid_valid_nxt_s = 1'b0;
            ready_nxt_s      = 1'b1;
        end else begin
            case ({commit_s, skid_valid_r, accept_s})
                // Commit with skid occupied: skid advances to head. Accept cannot
                // coincide because ready is low whenever skid is occupied.
                3'b110, 3'b111: begin
                    head_valid_nxt_s = 1'b1;
                    head_data_nxt_s  = skid_data_r;
                    head_rd_nxt_s    = skid_rd_r;
                    head_flags_nxt_s = skid_flags_r;
                    skid_valid_nxt_s = 1'b0;
                    ready_nxt_s      = 1'b1;
                end
                // Commit and accept with skid empty: new result replaces head, no bubble.
                3'b101: begin
                    head_valid_nxt_s = 1'b1;
                    head_data_nxt_s  = cap_data_s;
                    head_rd_nxt_s    = in_rd;
                    head_flags_nxt_s = in_flags;
                end
                // Commit only: head drains, outputs hold their last value.
                3'b100: begin
                    head_valid_nxt_s = 1'b0;
                end
                // Accept only: fill head if empty, else park in skid and stall upstream.
                3'b001: begin
                    if (head_valid_r) begin
                        skid_valid_nxt_s = 1'b1;
                        skid_data_nxt_s  = cap_data_s;
                        skid_rd_nxt_s    = in_rd;
                        skid_flags_nxt_s = in_flags;
                        ready_nxt_s      = 1'b0;
                    end else begin
                        head_valid_nxt_s = 1'b1;
                        head_data_nxt_s  = cap_data_s;
                        head_rd_nxt_s    = in_rd;
                        head_flags_nxt_s = in_flags;
                    end
                end
                default: begin
                    head_valid_nxt_s = head_valid_r;
                    skid_valid_nxt_s = skid_valid_r;
                    ready_nxt_s      = ready_r;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            head_valid_r <= 1'b0;
            head_data_r  <= {DATA_WIDTH{1'b0}};
            head_rd_r    <= {RD_WIDTH{1'b0}};
            head_flags_r <= {FLAG_WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {DATA_WIDTH{1'b0}};
            skid_rd_r    <= {RD_WIDTH{1'b0}};
            skid_flags_r <= {FLAG_WIDTH{1'b0}};
            ready_r      <= 1'b1;
            fflags_r     <= {FLAG_WIDTH{1'b0}};
        end else begin
            head_valid_r <= head_valid_nxt_s;
            head_data_r  <= head_data_nxt_s;
            head_rd_r    <= head_rd_nxt_s;
            head_flags_r <= head_flags_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            skid_data_r  <= skid_data_nxt_s;
            skid_rd_r    <= skid_rd_nxt_s;
            skid_flags_r <= skid_flags_nxt_s;
            ready_r      <= ready_nxt_s;
            fflags_r     <= fflags_nxt_s;
        end
    end

    assign out_ready  = ready_r;
    assign out_valid  = head_valid_r;
    assign out_data   = head_data_r;
    assign out_rd     = head_rd_r;
    assign out_flags  = head_flags_r;
    assign out_fflags = fflags_r;

endmodule

// File: tb/tb_fp_result_wb.sv
// Self-checking bench for fp_result_wb: scoreboard of expected writebacks plus a
// model of the sticky fflags CSR.
module tb_fp_result_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;
    logic        in_fmt;
    logic [4:0]  in_flags;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic [4:0]  out_flags;
    logic        in_flush;
    logic        in_csr_we;
    logic [4:0]  in_csr_wdata;
    logic [4:0]  out_fflags;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [63:0] d;
        logic [4:0]  rd;
        logic [4:0]  fl;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] exp_ff = 5'b0;

    fp_result_wb dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .out_ready(out_ready),
        .in_data(in_data), .in_fmt(in_fmt), .in_flags(in_flags), .in_rd(in_rd),
        .out_valid(out_valid), .in_ready(in_ready), .out_data(out_data), .out_rd(out_rd),
        .out_flags(out_flags), .in_flush(in_flush), .in_csr_we(in_csr_we),
        .in_csr_wdata(in_csr_wdata), .out_fflags(out_fflags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference capture transform.
    function automatic logic [63:0] model_capture(input logic [63:0] d, input logic fmt);
        logic [31:0] lo;
        lo = d[31:0];
`ifdef FP_CANON_NAN_EN
        if (fmt && (&lo[30:23]) && (|lo[22:0])) return 64'hFFFF_FFFF_7FC0_0000;
        if (!fmt && (&d[62:52]) && (|d[51:0])) return 64'h7FF8_0000_0000_0000;
`endif
        if (fmt) return {32'hFFFF_FFFF, lo};
        return d;
    endfunction

    // One clock: update scoreboard/fflags model from the handshake, advance, check fflags.
    task automatic tick();
        logic acc, com;
        logic [4:0] cflags;
        exp_t e;
        acc    = in_valid && out_ready;
        com    = out_valid && in_ready;
        cflags = 5'b0;
        if (in_flush) begin
            sb.delete();
            if (in_csr_we) exp_ff = in_csr_wdata;
        end else begin
            if (com) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: commit rd=%0d with no expected entry", out_rd);
                end else begin
                    e = sb.pop_front();
                    cflags = e.fl;
                    if (out_data !== e.d || out_rd !== e.rd || out_flags !== e.fl) begin
                        n_fail++;
                        $display("FAIL commit: got data=%h rd=%0d fl=%b, expected data=%h rd=%0d fl=%b",
                                 out_data, out_rd, out_flags, e.d, e.rd, e.fl);
                    end
                end
            end
            exp_ff = (in_csr_we ? in_csr_wdata : exp_ff) | cflags;
            if (acc) begin
                e.d  = model_capture(in_data, in_fmt);
                e.rd = in_rd;
                e.fl = in_flags;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_fflags !== exp_ff) begin
            n_fail++;
            $display("FAIL fflags: got %b expected %b", out_fflags, exp_ff);
        end
    endtask

    task automatic offer(input logic [63:0] d, input logic fmt, input logic [4:0] rd, input logic [4:0] fl);
        in_valid = 1'b1; in_data = d; in_fmt = fmt; in_rd = rd; in_flags = fl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 64'd0; in_fmt = 1'b0; in_flags = 5'd0;
        in_rd = 5'd0; in_ready = 1'b0; in_flush = 1'b0; in_csr_we = 1'b0; in_csr_wdata = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_fflags !== 5'b0 ||
            out_data !== 64'd0 || out_rd !== 5'd0 || out_flags !== 5'd0) begin
            n_fail++;
            $display("FAIL reset: got valid=%b ready=%b fflags=%b data=%h rd=%0d fl=%b, expected 0 1 0 0 0 0",
                     out_valid, out_ready, out_fflags, out_data, out_rd, out_flags);
        end
    endtask

    task automatic test_single();
        in_ready = 1'b1;
        offer(64'h0000_0000_3F80_0000, 1'b1, 5'd3, 5'd0);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hFFFF_FFFF_3F80_0000 || out_rd !== 5'd3) begin
            n_fail++;
            $display("FAIL single: got valid=%b data=%h rd=%0d, expected 1 ffffffff3f800000 3",
                     out_valid, out_data, out_rd);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        in_ready = 1'b0;
        offer(64'h0000_0000_4000_0000, 1'b0, 5'd1, 5'd0);
        tick();
        offer(64'h1234_5678_9ABC_DEF0, 1'b0, 5'd2, 5'd0);
        tick();
        n_checks++;
        if (out_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: got out_ready=%b expected 0", out_ready);
        end
        offer(64'h0000_0000_0000_0007, 1'b0, 5'd7, 5'd0);
        tick();
        n_checks++;
        if (out_ready !== 1'b0 || out_rd !== 5'd1 || sb.size() != 2) begin
            n_fail++;
            $display("FAIL bp_third: got ready=%b rd=%0d queued=%0d expected 0 1 2", out_ready, out_rd, sb.size());
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd2 || out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b rd=%0d ready=%b expected 1 2 1", out_valid, out_rd, out_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain: got valid=%b ready=%b expected 0 1", out_valid, out_ready);
        end
    endtask

    task automatic test_flags();
        in_ready = 1'b1;
        offer(64'h0000_0000_0000_0011, 1'b0, 5'd4, 5'b00001);
        tick();
        offer(64'h0000_0000_0000_0022, 1'b0, 5'd5, 5'b00100);
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_fflags !== 5'b00101) begin
            n_fail++;
            $display("FAIL flags_accum: got %b expected 00101", out_fflags);
        end
        offer(64'h0000_0000_0000_0033, 1'b0, 5'd6, 5'b10000);
        tick();
        in_valid = 1'b0;
        in_csr_we = 1'b1;
        in_csr_wdata = 5'b00000;
        tick();
        in_csr_we = 1'b0;
        n_checks++;
        if (out_fflags !== 5'b10000) begin
            n_fail++;
            $display("FAIL flags_csr_commit: got %b expected 10000", out_fflags);
        end
    endtask

    task automatic test_flush();
        in_ready = 1'b0;
        offer(64'h0000_0000_0000_0044, 1'b0, 5'd8, 5'b01000);
        tick();
        offer(64'h0000_0000_0000_0055, 1'b0, 5'd9, 5'b01000);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_fill: got valid=%b ready=%b expected 1 0", out_valid, out_ready);
        end
        in_flush = 1'b1;
        in_ready = 1'b1;
        offer(64'h0000_0000_0000_0066, 1'b0, 5'd10, 5'b00010);
        tick();
        in_flush = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_fflags !== 5'b10000) begin
            n_fail++;
            $display("FAIL flush: got valid=%b ready=%b fflags=%b expected 0 1 10000",
                     out_valid, out_ready, out_fflags);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_nan();
        logic [63:0] exp_s, exp_d;
`ifdef FP_CANON_NAN_EN
        exp_s = 64'hFFFF_FFFF_7FC0_0000;
        exp_d = 64'h7FF8_0000_0000_0000;
`else
        exp_s = 64'hFFFF_FFFF_7F80_0001;
        exp_d = 64'h7FF0_0000_0000_0001;
`endif
        in_ready = 1'b1;
        offer(64'h0000_0000_7F80_0001, 1'b1, 5'd11, 5'b10000);
        tick();
        n_checks++;
        if (out_data !== exp_s || out_flags !== 5'b10000) begin
            n_fail++;
            $display("FAIL nan_single: got %h fl=%b expected %h fl=10000", out_data, out_flags, exp_s);
        end
        offer(64'h7FF0_0000_0000_0001, 1'b0, 5'd12, 5'd0);
        tick();
        n_checks++;
        if (out_data !== exp_d) begin
            n_fail++;
            $display("FAIL nan_double: got %h expected %h", out_data, exp_d);
        end
        offer(64'hDEAD_BEEF_7F80_0000, 1'b1, 5'd13, 5'd0);
        tick();
        n_checks++;
        if (out_data !== 64'hFFFF_FFFF_7F80_0000) begin
            n_fail++;
            $display("FAIL inf_single: got %h expected ffffffff7f800000", out_data);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int cnt;
        in_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            offer({$urandom, $urandom}, 1'($urandom_range(0, 1)), 5'(i + 16), 5'($urandom_range(0, 31)));
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_stream[%0d]: got valid=%b ready=%b expected 1 1", i, out_valid, out_ready);
            end
        end
        in_valid = 1'b0;
        // Random valid/ready traffic; in_* held while stalled.
        for (int i = 0; i < 60; i++) begin
            if (!(in_valid && !out_ready)) begin
                if ($urandom_range(0, 3) != 0)
                    offer({$urandom, $urandom}, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)));
                else
                    in_valid = 1'b0;
            end
            in_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        while (sb.size() != 0 && cnt < 10) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending valid=%b expected 0 0", sb.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid();
        in_ready = 1'b0;
        offer(64'h0000_0000_0000_0077, 1'b0, 5'd14, 5'b00011);
        tick();
        offer(64'h0000_0000_0000_0088, 1'b0, 5'd15, 5'b00011);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        exp_ff = 5'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_fflags !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got valid=%b ready=%b fflags=%b expected 0 1 0",
                     out_valid, out_ready, out_fflags);
        end
        in_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_flags();
        test_flush();
        test_nan();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
